// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg
//   Shared constants and helpers for the time-multiplexed serial pattern
//   detector (seq_detect_sched) and its round-robin arbiter.
//   - DEF_PATTERN / DEF_LEN : pattern loaded at reset (10110, length 5)
//   - LEN_MIN / PMAX_DEF    : legal pattern length floor, default history width
//   - pattern_hit()         : length-masked compare of a history against a pattern
package seq_detect_pkg;

    localparam int PMAX_DEF = 8;
    localparam int LEN_MIN  = 2;

    // Working width of pattern_hit(); a 4-bit length can address at most 15 bits.
    localparam int CMP_W = 16;

    localparam logic [7:0] DEF_PATTERN = 8'b0001_0110;
    localparam logic [3:0] DEF_LEN     = 4'd5;

    // True when the low 'len' bits of hist equal the low 'len' bits of pat.
    // The newest received bit sits at bit 0 of the history, the oldest of the
    // window at bit len-1, matching the pattern's first-received-bit-at-MSB order.
    function automatic logic pattern_hit(input logic [CMP_W-1:0] hist,
                                         input logic [CMP_W-1:0] pat,
                                         input logic [3:0]       len);
        logic [CMP_W-1:0] mask;
        mask = (CMP_W'(1) << len) - CMP_W'(1);
        return ((hist ^ pat) & mask) == '0;
    endfunction

endpackage

// File: rtl/seq_detect_sched_rr_arbiter.sv
// rr_arbiter
//   Pure combinational rotating-priority arbiter.
//   - req : request vector, one bit per channel
//   - ptr : index of the last granted channel; search starts at ptr+1 mod N
//   - gnt : one-hot grant to the first requester found, or all-zero
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);

    logic          found;
    logic [PW-1:0] idx;

    // NOTE: every signal driven here gets a default at the top of the block so
    // no path leaves it unassigned; otherwise a latch would be inferred.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_detect_sched.sv
// seq_detect_sched
//   Serial pattern detector shared by NCH bit streams. A round-robin arbiter
//   grants one channel bit per cycle to a single compare engine; each channel
//   keeps its own shift history and fill count so streams match independently,
//   with overlapping occurrences each reported.
//   Ports:
//   - clk, rst          : clock, asynchronous active-high reset
//   - in_valid, in_bit  : per-channel bit-valid and serial data bit
//   - in_ready          : per-channel grant (one-hot or zero); transfer = valid & ready
//   - cfg_load          : single-cycle pulse loading cfg_pattern / cfg_len
//   - cfg_pattern       : pattern, first-received bit at index cfg_len-1
//   - cfg_len           : pattern length, legal range LEN_MIN..PMAX
//   - cfg_err           : one-cycle pulse when a cfg_load carried an illegal length
//   - match_valid       : one-cycle pulse, the cycle after the matching transfer
//   - match_ch          : channel that produced the reported match
//   - match_cnt         : saturating total match count
module seq_detect_sched
    import seq_detect_pkg::*;
#(
    parameter  int NCH  = 4,
    parameter  int PMAX = PMAX_DEF,
    parameter  int CW   = 16,
    localparam int IW   = $clog2(NCH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NCH-1:0]  in_valid,
    input  logic [NCH-1:0]  in_bit,
    output logic [NCH-1:0]  in_ready,
    input  logic            cfg_load,
    input  logic [PMAX-1:0] cfg_pattern,
    input  logic [3:0]      cfg_len,
    output logic            cfg_err,
    output logic            match_valid,
    output logic [IW-1:0]   match_ch,
    output logic [CW-1:0]   match_cnt
);

    // Arbitration state and active configuration
    logic [IW-1:0]   rr_ptr;
    logic [NCH-1:0]  gnt;
    logic [PMAX-1:0] pat_q;
    logic [3:0]      len_q;

    // Per-channel context: shift history (newest bit at [0]) and fill count
    logic [PMAX-1:0] hist [NCH];
    logic [3:0]      fill [NCH];

    // Shared compare engine
    logic            xfer;
    logic [IW-1:0]   xfer_idx;
    logic [PMAX-1:0] new_hist;
    logic [3:0]      new_fill;
    logic            hit;
    logic            cfg_ok;

    rr_arbiter #(.N(NCH)) u_arb (
        .req (in_valid),
        .ptr (rr_ptr),
        .gnt (gnt)
    );

    // A configuration load owns the cycle: no channel is granted.
    assign in_ready = cfg_load ? '0 : gnt;
    assign xfer     = |in_ready;
    assign cfg_ok   = (int'(cfg_len) >= LEN_MIN) && (int'(cfg_len) <= PMAX);

    always_comb begin
        xfer_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (in_ready[i]) xfer_idx = IW'(i);
        end
        new_hist = {hist[xfer_idx][PMAX-2:0], in_bit[xfer_idx]};
        // Fill saturates at the pattern length: once the window is full it stays full.
        new_fill = (fill[xfer_idx] < len_q) ? fill[xfer_idx] + 4'd1 : len_q;
        hit      = xfer && (new_fill >= len_q) &&
                   pattern_hit(CMP_W'(new_hist), CMP_W'(pat_q), len_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= IW'(NCH - 1);
            pat_q       <= PMAX'(DEF_PATTERN);
            len_q       <= DEF_LEN;
            match_valid <= 1'b0;
            match_ch    <= '0;
            match_cnt   <= '0;
            cfg_err     <= 1'b0;
            // NOTE: the channel contexts are small register files whose zero
            // state is architecturally visible (fill gates matching), so they
            // are reset explicitly rather than left as an unreset memory.
            for (int i = 0; i < NCH; i++) begin
                hist[i] <= '0;
                fill[i] <= '0;
            end
        end else begin
            match_valid <= hit;
            cfg_err     <= 1'b0;

            if (xfer) begin
                rr_ptr         <= xfer_idx;
                hist[xfer_idx] <= new_hist;
                fill[xfer_idx] <= new_fill;
            end

            if (hit) begin
                match_ch <= xfer_idx;
                if (match_cnt != '1) match_cnt <= match_cnt + CW'(1);
            end

            // cfg_load and a transfer are mutually exclusive, so clearing the
            // contexts here never races with a history update above.
            if (cfg_load) begin
                if (cfg_ok) begin
                    pat_q <= cfg_pattern;
                    len_q <= cfg_len;
                    for (int i = 0; i < NCH; i++) begin
                        hist[i] <= '0;
                        fill[i] <= '0;
                    end
                end else begin
                    cfg_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_sched.sv
// tb_seq_detect_sched
//   Directed scenarios plus randomized traffic against a stream-level
//   reference model: each channel's received bits since the last clear are
//   kept in a queue, and a match is declared when the most recent len bits
//   equal the pattern read first-bit-first.
module tb_seq_detect_sched;

    localparam int NCH  = 4;
    localparam int PMAX = 8;
    localparam int CW   = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [NCH-1:0]  in_valid;
    logic [NCH-1:0]  in_bit;
    logic [NCH-1:0]  in_ready;
    logic            cfg_load;
    logic [PMAX-1:0] cfg_pattern;
    logic [3:0]      cfg_len;
    logic            cfg_err;
    logic            match_valid;
    logic [1:0]      match_ch;
    logic [CW-1:0]   match_cnt;

    // Second instance with a 2-bit counter for the saturation check
    logic [1:0]      s_valid;
    logic [1:0]      s_bit;
    logic [1:0]      s_ready;
    logic            s_load;
    logic [PMAX-1:0] s_pattern;
    logic [3:0]      s_len;
    logic            s_err;
    logic            s_mv;
    logic            s_ch;
    logic [1:0]      s_cnt;

    always #5 clk = ~clk;

    seq_detect_sched #(.NCH(NCH), .PMAX(PMAX), .CW(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_bit      (in_bit),
        .in_ready    (in_ready),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_err     (cfg_err),
        .match_valid (match_valid),
        .match_ch    (match_ch),
        .match_cnt   (match_cnt)
    );

    seq_detect_sched #(.NCH(2), .PMAX(PMAX), .CW(2)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (s_valid),
        .in_bit      (s_bit),
        .in_ready    (s_ready),
        .cfg_load    (s_load),
        .cfg_pattern (s_pattern),
        .cfg_len     (s_len),
        .cfg_err     (s_err),
        .match_valid (s_mv),
        .match_ch    (s_ch),
        .match_cnt   (s_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit       m_stream [NCH][$];
    int       m_ptr;
    bit [7:0] m_pat;
    int       m_len;
    int       m_cnt;

    function automatic void model_clear_streams();
        for (int i = 0; i < NCH; i++) m_stream[i].delete();
    endfunction

    function automatic void model_reset();
        model_clear_streams();
        m_ptr = NCH - 1;
        m_pat = 8'b0001_0110;
        m_len = 5;
        m_cnt = 0;
    endfunction

    // Channel served next: first requester after the last one served.
    function automatic int model_pick(input logic [NCH-1:0] v);
        for (int k = 1; k <= NCH; k++) begin
            int c;
            c = (m_ptr + k) % NCH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic bit model_match(input int ch);
        int n;
        n = m_stream[ch].size();
        if (n < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (m_stream[ch][n - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock cycle: apply inputs, check the grant mid-cycle, advance the
    // model at the edge and check the registered outputs just after it.
    task automatic cycle(input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                         input logic ld, input logic [7:0] pat, input logic [3:0] ln,
                         output int gch);
        int ch;
        bit exp_mv;
        bit exp_err;
        int exp_ch;
        in_valid    = v;
        in_bit      = b;
        cfg_load    = ld;
        cfg_pattern = pat;
        cfg_len     = ln;
        #1;
        ch = ld ? -1 : model_pick(v);
        check("in_ready", in_ready, (ch < 0) ? 0 : (1 << ch));
        @(posedge clk);
        #1;
        exp_mv  = 1'b0;
        exp_err = 1'b0;
        exp_ch  = 0;
        if (ch >= 0) begin
            m_stream[ch].push_back(b[ch]);
            if (m_stream[ch].size() > 16) void'(m_stream[ch].pop_front());
            m_ptr = ch;
            if (model_match(ch)) begin
                exp_mv = 1'b1;
                exp_ch = ch;
                if (m_cnt < (1 << CW) - 1) m_cnt++;
            end
        end
        if (ld) begin
            if (ln >= 2 && ln <= PMAX) begin
                m_pat = pat;
                m_len = ln;
                model_clear_streams();
            end else begin
                exp_err = 1'b1;
            end
        end
        check("match_valid", match_valid, exp_mv);
        if (exp_mv) check("match_ch", match_ch, exp_ch);
        check("match_cnt", match_cnt, m_cnt);
        check("cfg_err", cfg_err, exp_err);
        gch = ch;
    endtask

    task automatic send(input int ch, input bit b);
        int g;
        cycle(NCH'(1) << ch, NCH'(b) << ch, 1'b0, 8'h00, 4'h0, g);
    endtask

    // Sends n bits on one channel, bits[n-1] first.
    task automatic send_bits(input int ch, input int n, input logic [15:0] bits);
        for (int k = n - 1; k >= 0; k--) send(ch, bits[k]);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] ln);
        int g;
        cycle('0, '0, 1'b1, pat, ln, g);
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        in_valid    = '0;
        in_bit      = '0;
        cfg_load    = 1'b0;
        cfg_pattern = '0;
        cfg_len     = '0;
        s_valid     = '0;
        s_bit       = '0;
        s_load      = 1'b0;
        s_pattern   = '0;
        s_len       = '0;
        #3;
        model_reset();
        check("rst_in_ready", in_ready, 0);
        check("rst_match_valid", match_valid, 0);
        check("rst_match_ch", match_ch, 0);
        check("rst_match_cnt", match_cnt, 0);
        check("rst_cfg_err", cfg_err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g;
        int k0;
        int k1;
        int nmatch;
        bit seq [5];
        logic [15:0] sat_bits;
        seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

        // Overlap on channel 0
        do_reset();
        send_bits(0, 8, 16'b1011_0110);
        check("overlap_cnt", match_cnt, 2);

        // Fairness: ch0 and ch1 continuously valid
        do_reset();
        k0 = 0;
        k1 = 0;
        for (int k = 0; k < 10; k++) begin
            logic [NCH-1:0] b;
            b    = '0;
            b[0] = (k0 < 5) ? seq[k0] : 1'b0;
            b[1] = (k1 < 5) ? seq[k1] : 1'b0;
            cycle(4'b0011, b, 1'b0, 8'h00, 4'h0, g);
            check("fair_alternate", g, k % 2);
            if (g == 0) k0++;
            if (g == 1) k1++;
        end
        check("fair_cnt", match_cnt, 2);

        // Context isolation between ch2 and ch3
        do_reset();
        send_bits(2, 3, 16'b101);
        send_bits(3, 2, 16'b10);
        send_bits(2, 2, 16'b10);
        check("iso_cnt", match_cnt, 1);
        send_bits(3, 3, 16'b110);
        check("iso_ch3", match_ch, 3);

        // Reconfiguration to 111, length 3, with ch0 stalled during the load
        do_reset();
        send_bits(0, 4, 16'b1011);
        cycle(4'b0001, 4'b0000, 1'b1, 8'b0000_0111, 4'd3, g);
        send_bits(0, 1, 16'b0);
        send_bits(0, 4, 16'b1111);
        check("reconf_cnt", match_cnt, 2);

        // Illegal lengths keep pattern and histories
        do_reset();
        send_bits(0, 4, 16'b1011);
        load(8'b0000_0111, 4'd1);
        load(8'b0000_0111, 4'd9);
        send_bits(0, 1, 16'b0);
        check("badcfg_cnt", match_cnt, 1);

        // Randomized traffic with occasional (sometimes illegal) reloads
        do_reset();
        load(8'($urandom), 4'($urandom_range(2, 4)));
        for (int k = 0; k < 600; k++) begin
            logic ld;
            ld = ($urandom_range(0, 39) == 0);
            cycle(NCH'($urandom), NCH'($urandom), ld, 8'($urandom),
                  4'($urandom_range(0, 9) < 8 ? $urandom_range(2, 4) : $urandom_range(0, 15)), g);
        end

        // Reset while a match is being reported
        do_reset();
        send_bits(0, 5, 16'b10110);
        check("pre_rst_match", match_valid, 1);
        rst = 1'b1;
        #1;
        check("midrst_match_valid", match_valid, 0);
        check("midrst_match_cnt", match_cnt, 0);
        do_reset();

        // Saturation of a 2-bit match counter: four matches leave it at 3
        nmatch   = 0;
        sat_bits = 16'b1011_0110_1101_10_00;
        for (int k = 15; k >= 2; k--) begin
            s_valid = 2'b01;
            s_bit   = {1'b0, sat_bits[k]};
            #1;
            check("sat_ready", s_ready, 2'b01);
            @(posedge clk);
            #1;
            if (s_mv) nmatch++;
        end
        s_valid = '0;
        check("sat_matches", nmatch, 4);
        check("sat_cnt", s_cnt, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_sched.md
Name: seq_detect_sched

Overview:
- Time-multiplexed serial pattern detector shared among NCH independent serial bit streams.
- A round-robin scheduler grants one channel bit per cycle to a single shared compare engine.
- Per-channel history context is saved and restored so that each stream is matched independently, with overlap allowed.
- The pattern is programmable at run time and defaults to 10110. The block replaces per-stream hard-coded sequence FSMs where several serial links need the same detector.

Parameters:
- NCH, 4, number of serial channels (2..8).
- PMAX, 8, maximum pattern length in bits; width of each channel history.
- CW, 16, width of the saturating match counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  NCH  per-channel bit-valid
- in_bit  in  NCH  per-channel serial data bit
- in_ready  out  NCH  per-channel grant, one-hot or zero
- cfg_load  in  1  load new pattern (single-cycle pulse)
- cfg_pattern  in  PMAX  pattern; first-received bit is at index cfg_len-1
- cfg_len  in  4  pattern length
- cfg_err  out  1  one-cycle pulse: cfg_len rejected
- match_valid  out  1  one-cycle pulse: match detected
- match_ch  out  $clog2(NCH)  channel that matched
- match_cnt  out  CW  total matches, saturating

Behaviour:
- Reset state:
  - in_ready=0, match_valid=0, match_ch=0, match_cnt=0, cfg_err=0.
  - Pattern register = 5'b10110 zero-extended; length register = 5.
  - All histories = 0; all fill counters = 0.
  - RR pointer = NCH-1, so channel 0 has first priority.
- Arbitration:
  - in_ready is combinational from in_valid and the RR pointer.
  - The highest-priority requester is the first set in_valid[i] searching upward from pointer+1, modulo NCH.
  - in_ready[i]=1 only for that channel. in_ready never asserts without the matching in_valid.
  - The pointer updates to the granted index on each transfer; it is held when there is no request.
  - A transfer is in_valid[i] & in_ready[i]. At most one transfer occurs per cycle.
- Channel update on transfer, applied at the clock edge:
  - hist[i] <= {hist[i][PMAX-2:0], in_bit[i]}.
  - fill[i] saturates at the length register value.
- Match rule, evaluated on the post-shift history:
  - Match when the new fill >= len and new_hist[len-1:0] == pattern[len-1:0].
  - Registered outputs: match_valid=1 and match_ch=i in the cycle after the transfer (latency 1).
  - match_cnt increments in the same cycle and saturates at 2^CW-1.
- Overlap: histories are never cleared on a match, so overlapping occurrences are each reported.
- Non-granted channels keep their hist and fill unchanged. A stalled in_valid loses no data.
- Configuration:
  - When cfg_load=1, in_ready is forced to 0 in that cycle; no transfer occurs.
  - If 2 <= cfg_len <= PMAX:
    - The pattern and length registers update at the edge.
    - All hist and fill values clear to 0.
    - The RR pointer is unchanged.
  - Otherwise the registers are unchanged, histories are kept, and cfg_err pulses for one cycle at the next edge.
  - A match pending from the prior cycle's transfer is still reported.
- Reset mid-stream: everything returns to reset values immediately. A pending match_valid is dropped.

Decomposition:
- Package seq_detect_pkg holds:
  - constants DEF_PATTERN=8'b0001_0110 and DEF_LEN=4'd5;
  - localparams LEN_MIN=2 and PMAX default;
  - the function computing the length-masked compare.
- Sub-module rr_arbiter (parameter N):
  - inputs req[N-1:0] and ptr; output one-hot gnt;
  - pure combinational rotate-priority logic.
- The top level holds the pointer, contexts, config and outputs.

Test Plan:
- Overlap on ch0 alone: ch0 sends 1,0,1,1,0,1,1,0 back-to-back. Expect match_valid, match_ch=0 after the 5th and 8th transfers; match_cnt=2.
- Fairness: ch0 and ch1 held valid continuously from reset. Expect in_ready to alternate 0001, 0010, 0001, ... Each channel independently reports a match after its own 5th bit 1,0,1,1,0.
- Context isolation: ch2 sends 1,0,1; ch3 sends 1,0; ch2 then sends 1,0. Expect match_ch=2 only. ch3 history is unaffected and 2 bits full.
- Reconfiguration: cfg_load with cfg_pattern=8'b0000_0111, cfg_len=3 after ch0 sends 1,0,1,1. Expect in_ready=0 in the load cycle. No match on ch0's next bit 0. A fresh 1,1,1 then matches; a 4th 1 matches again.
- Bad config: cfg_len=1, and separately cfg_len=9. Expect cfg_err pulse, pattern stays 10110, and histories are kept: a stream already at 1,0,1,1 matches on the next 0.
- Reset and saturation: assert rst mid-match-cycle. Expect match_valid=0 and match_cnt=0 immediately. With CW forced to 2, four matches leave match_cnt=3.
